bus_buffer_fifo: RTL and testbench
==================================

BUS_BUFFER_FIFO -- requirements
Module: bus_buffer_fifo

Interface
REQ-001 Parameter WIDTH, default 4: data bus width in bits, minimum 1.
REQ-002 Parameter DEPTH, default 4: FIFO entries; power of two, minimum 2.
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port din  input  WIDTH  write data.
REQ-006 Port wr_en  input  1  write request.
REQ-007 Port rd_en  input  1  read/pop request.
REQ-008 Port oe  input  1  output enable for the tri-state bus.
REQ-009 Port dout  output  WIDTH  tri-state data bus, head-of-FIFO value.
REQ-010 Port full  output  1  high when count == DEPTH.
REQ-011 Port empty  output  1  high when count == 0.
REQ-012 Port count  output  clog2(DEPTH)+1  current occupancy.
REQ-013 Port overflow  output  1  sticky error flag for a rejected write.
REQ-014 Port underflow  output  1  sticky error flag for a rejected read.

Function
REQ-015 Write accepted when wr_en=1 and (full=0 or rd_en=1); din stored at the write pointer, pointer advances modulo DEPTH.
REQ-016 Read accepted when rd_en=1 and empty=0; read pointer advances modulo DEPTH.
REQ-017 Simultaneous accepted read and write leaves count unchanged; at full both are accepted.
REQ-018 At empty with wr_en=1 and rd_en=1: write accepted, read rejected, count becomes 1.
REQ-019 Rejected write (wr_en=1, full=1, rd_en=0) leaves FIFO contents unchanged.
REQ-020 Rejected read (rd_en=1, empty=1) leaves pointers unchanged.
REQ-021 First-word fall-through: head entry visible on dout in the cycle after it is written; zero-cycle read latency.
REQ-022 dout = head entry when oe=1 and empty=0; all bits high-impedance otherwise, combinationally from oe.
REQ-023 oe has no effect on FIFO state; a pop with oe=0 discards the head silently.
REQ-024 full, empty, count are registered-state derived; no combinational path from wr_en/rd_en.
REQ-025 Pointers wrap from DEPTH-1 to 0 with no gap or duplication.

Reset
REQ-026 reset asserted at any time, including mid-operation, clears pointers, count=0, empty=1, full=0, overflow=0, underflow=0 immediately.
REQ-027 dout is high-impedance throughout reset regardless of oe.
REQ-028 Storage array contents are not reset; unread data is discarded.
REQ-029 First write is accepted on the first rising edge after reset deasserts.

Configuration
REQ-030 Macro BUS_BUFFER_FIFO_ERR_EN: when defined, overflow sets on a rejected write (REQ-019) and underflow on a rejected read (REQ-020); both hold until reset.
REQ-031 Without BUS_BUFFER_FIFO_ERR_EN: overflow and underflow ports remain present and are tied to 0; no flag logic is synthesised.

Structure
REQ-032 Shared package bus_buffer_pkg holds default WIDTH/DEPTH constants and the pointer-width function clog2.
REQ-033 One sub-module bus_tristate (WIDTH-parameterised, data plus enable in, tri-state out) implements REQ-022.

Verification
REQ-034 Reset, then oe=0, din=4, wr_en=1 for 1 cycle -> count=1, empty=0, dout=zzzz; then oe=1 -> dout=0100.
REQ-035 Write 1,2,3,4 -> full=1, count=4; fifth write din=5 -> rejected, overflow=1 (ERR_EN), head still 0001.
REQ-036 Full FIFO, wr_en=1 din=5 with rd_en=1 -> count stays 4, dout sequence after draining: 2,3,4,5.
REQ-037 Empty FIFO, rd_en=1 -> count=0, underflow=1 (ERR_EN); without macro underflow=0.
REQ-038 Push 6 and pop 6 values alternately (>DEPTH) -> data order preserved across pointer wrap.
REQ-039 reset asserted mid-burst at count=3 -> count=0, empty=1, dout=zzzz immediately, before next clock edge.

Source files
------------

// File: rtl/bus_buffer_pkg.sv
// Shared constants and helpers for the bus buffer FIFO and its tri-state driver.
package bus_buffer_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 4;

  // Smallest r with 2**r >= n; also used to size the pointers.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/bus_tristate.sv
// Tri-state bus driver: passes d onto y when en is high, floats y otherwise.
module bus_tristate #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  output tri logic [WIDTH-1:0] y
);

  assign y = en ? d : {WIDTH{1'bz}};

endmodule

// File: rtl/bus_buffer_fifo.sv
// First-word fall-through FIFO driving a tri-state output bus.
// Define BUS_BUFFER_FIFO_ERR_EN to build the sticky overflow/underflow flags.
module bus_buffer_fifo
  import bus_buffer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         din,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic                     oe,
  output tri logic [WIDTH-1:0]     dout,
  output logic                     full,
  output logic                     empty,
  output logic [clog2(DEPTH):0]    count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    cnt;
  logic             wr_acc;
  logic             rd_acc;

  assign count = cnt;
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

  // A write into a full FIFO is fine when the head leaves in the same cycle.
  assign wr_acc = wr_en & (~full | rd_en);
  assign rd_acc = rd_en & ~empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr] <= din;
  end

  bus_tristate #(.WIDTH(WIDTH)) u_tristate (
    .d  (mem[rptr]),
    .en (oe & ~empty & ~reset),
    .y  (dout)
  );

`ifdef BUS_BUFFER_FIFO_ERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en & full & ~rd_en) overflow <= 1'b1;
      if (rd_en & empty)         underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_bus_buffer_fifo.sv
// Randomized and directed bench for bus_buffer_fifo against a queue-based model.
module tb_bus_buffer_fifo;

  localparam int W = 4;
  localparam int D = 4;
`ifdef BUS_BUFFER_FIFO_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  localparam logic [W-1:0] FLOAT = '1;  // a floating bus reads as all ones via the pullups

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] din = '0;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic         oe = 1'b0;
  wire  [W-1:0] dout;
  logic         full, empty, overflow, underflow;
  logic [2:0]   count;

  for (genvar i = 0; i < W; i++) begin : g_pu
    pullup (dout[i]);
  end

  bus_buffer_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .oe(oe), .dout(dout), .full(full), .empty(empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] q[$];
  bit           m_ovf;
  bit           m_unf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_dout();
    if (reset || !oe || q.size() == 0) return FLOAT;
    return q[0];
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(q.size()));
    chk({tag, "_empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, "_full"},  32'(full),  32'(q.size() == D));
    chk({tag, "_ovf"},   32'(overflow),  32'(m_ovf));
    chk({tag, "_unf"},   32'(underflow), 32'(m_unf));
    chk({tag, "_dout"},  32'(dout), 32'(exp_dout()));
  endtask

  // One clock: apply inputs, let the edge happen, advance the model, check.
  task automatic cyc(input logic w, input logic r, input logic [W-1:0] d,
                     input logic o, input string tag);
    bit was_full, was_empty;
    wr_en = w; rd_en = r; din = d; oe = o;
    @(posedge clk);
    was_full  = (q.size() == D);
    was_empty = (q.size() == 0);
    if (r && !was_empty) void'(q.pop_front());
    if (w && (!was_full || r)) q.push_back(d);
    if (ERR && w && was_full && !r) m_ovf = 1'b1;
    if (ERR && r && was_empty) m_unf = 1'b1;
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #1;
    check_all(tag);
    @(posedge clk);
    #1;
    reset = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    // Power-up reset and basic write with bus disabled then enabled.
    do_reset("rst0");
    cyc(1'b1, 1'b0, 4'd4, 1'b0, "r34a");
    chk("r34_dout_z", 32'(dout), 32'(FLOAT));
    chk("r34_count", 32'(count), 32'd1);
    oe = 1'b1; #1;
    chk("r34_dout", 32'(dout), 32'h4);

    // Fill, reject an extra write, simultaneous push/pop at full, drain.
    do_reset("rst1");
    for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b0, 4'(i), 1'b1, "r35fill");
    chk("r35_full", 32'(full), 32'd1);
    cyc(1'b1, 1'b0, 4'd5, 1'b1, "r35ovf");
    chk("r35_head", 32'(dout), 32'h1);
    chk("r35_ovf", 32'(overflow), 32'(ERR));
    cyc(1'b1, 1'b1, 4'd5, 1'b1, "r36rw");
    chk("r36_count", 32'(count), 32'd4);
    for (int i = 2; i <= 5; i++) begin
      chk("r36_drain", 32'(dout), 32'(i));
      cyc(1'b0, 1'b1, 4'd0, 1'b1, "r36pop");
    end

    // Underflow from empty, then push+pop together at empty.
    cyc(1'b0, 1'b1, 4'd0, 1'b1, "r37unf");
    chk("r37_unf", 32'(underflow), 32'(ERR));
    cyc(1'b1, 1'b1, 4'd9, 1'b1, "r18");
    chk("r18_count", 32'(count), 32'd1);
    cyc(1'b0, 1'b1, 4'd0, 1'b0, "r23pop");

    // Alternating push/pop across the pointer wrap.
    do_reset("rst2");
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 4'(10 + i), 1'b1, "r38push");
      chk("r38_order", 32'(dout), 32'(10 + i));
      cyc(1'b0, 1'b1, 4'd0, 1'b1, "r38pop");
    end

    // Reset mid-burst at count 3 must take effect before the next edge.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 4'(i + 7), 1'b1, "r39fill");
    chk("r39_pre", 32'(count), 32'd3);
    wr_en = 1'b1;
    do_reset("r39rst");
    cyc(1'b1, 1'b0, 4'd6, 1'b1, "r29first");

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 79) == 0) do_reset("rnd_rst");
      else cyc(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
               4'($urandom), 1'($urandom_range(0, 3) != 0), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
